// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default widths for pipeline stages.
package pipe_pkg;
    typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_FULL} pipe_state_t;
    localparam int CTRL_W_D = 26;
    localparam int DATA_W_D = 160;
    localparam int CNT_W_D  = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all ones; cleared only by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready stage register with one-entry skid buffer, flush and stall counter.
// in_ready comes from the skid flop alone, so no ready path crosses the stage combinationally.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_D,
    parameter int DATA_W = DATA_W_D,
    parameter int CNT_W  = CNT_W_D
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              mvalid, svalid;
    logic [CTRL_W-1:0] mctrl, sctrl;
    logic [DATA_W-1:0] mdata, sdata;
    pipe_state_t       state, nxt;
    logic              in_fire, out_fire, load_m_in, load_m_skid, load_s;

    assign state     = svalid ? PS_FULL : mvalid ? PS_ONE : PS_EMPTY;
    assign in_ready  = !svalid;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = mvalid && out_ready;
    assign out_valid = mvalid;
    assign out_ctrl  = mctrl;
    assign out_data  = mdata;

    always_comb begin
        nxt         = state;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        case (state)
            PS_EMPTY: if (in_fire) begin
                nxt       = PS_ONE;
                load_m_in = 1'b1;
            end
            PS_ONE: begin
                load_m_in = in_fire && out_fire;
                load_s    = in_fire && !out_fire;
                nxt       = load_s ? PS_FULL : (out_fire && !in_fire) ? PS_EMPTY : PS_ONE;
            end
            PS_FULL: if (out_fire) begin
                nxt         = PS_ONE;
                load_m_skid = 1'b1;
            end
            default: nxt = PS_EMPTY;
        endcase
        if (flush) begin
            nxt         = PS_EMPTY;
            load_m_in   = 1'b0;
            load_m_skid = 1'b0;
            load_s      = 1'b0;
        end
    end

    // mctrl is zeroed on every entry to EMPTY so out_ctrl reads 0 whenever out_valid is low
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            mvalid <= 1'b0;
            svalid <= 1'b0;
            mctrl  <= '0;
            mdata  <= '0;
            sctrl  <= '0;
            sdata  <= '0;
        end else begin
            mvalid <= nxt != PS_EMPTY;
            svalid <= nxt == PS_FULL;
            mctrl  <= nxt == PS_EMPTY ? '0 : load_m_in ? in_ctrl : load_m_skid ? sctrl : mctrl;
            mdata  <= load_m_in ? in_data : load_m_skid ? sdata : mdata;
            sctrl  <= flush ? '0 : load_s ? in_ctrl : sctrl;
            if (load_s) sdata <= in_data;
        end

    sat_counter #(.W(CNT_W)) u_stall (
        .clk   (clk),
        .reset (reset),
        .inc   (mvalid && !out_ready),
        .count (stall_cnt)
    );
endmodule
